// File: rtl/guess_pkg.sv
`default_nettype none
// ============================================================================
// Module      : guess_pkg
// Description : Shared types and constants for the guessing-game round
//               sequencer: FSM state encoding, Decision result codes and a
//               saturating score increment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package guess_pkg;

  // Round sequencer states
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD       = 3'd1,
    ST_WAIT_GUESS = 3'd2,
    ST_EVAL       = 3'd3,
    ST_RESULT     = 3'd4,
    ST_DONE       = 3'd5
  } state_t;

  // Decision verdict codes; anything else is "no verdict"
  localparam logic [1:0] RES_HIT  = 2'b01;
  localparam logic [1:0] RES_MISS = 2'b10;

  localparam logic [3:0] C_SCORE_MAX = 4'd15;

  // Score increment that sticks at the 4-bit ceiling
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == C_SCORE_MAX) ? v : v + 4'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/guess_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : guess_round_ctrl
// Description : Match/round sequencer for the Decision unit. Latches a secret
//               per round, accepts player guesses over valid/ready, presents
//               one guess at a time to Decision, waits its latency, and keeps
//               tries, score and round index.
// Revision    : 1.0 - initial release
// ============================================================================
module guess_round_ctrl
  import guess_pkg::*;
#(
  parameter int MAX_TRIES = 3,
  parameter int ROUNDS    = 4,
  parameter int DEC_LAT   = 1
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       start,
  input  logic [1:0] secret_in,
  input  logic       guess_valid,
  input  logic [1:0] guess,
  output logic       guess_ready,
  output logic [1:0] Correct_guess,
  output logic [1:0] In_wr,
  output logic       dec_reset,
  input  logic [1:0] Result,
  output logic [2:0] tries_left,
  output logic [3:0] score,
  output logic [3:0] round_idx,
  output logic       round_done,
  output logic       round_win,
  output logic       match_done
);

  // Counter wide enough to hold DEC_LAT itself
  localparam int               C_CNT_W      = (DEC_LAT < 2) ? 1 : $clog2(DEC_LAT + 1);
  localparam logic [C_CNT_W-1:0] C_DEC_LOAD = C_CNT_W'(DEC_LAT);
  localparam logic [2:0]       C_MAX_TRIES  = 3'(MAX_TRIES);
  localparam logic [3:0]       C_LAST_ROUND = 4'(ROUNDS - 1);

  state_t               r_state;
  state_t               w_next;
  logic [C_CNT_W-1:0]   r_dec_cnt;
  logic                 r_won;

  logic                 w_eval_done;
  logic                 w_hit;
  logic                 w_last_try;
  logic                 w_last_round;

  // Decision verdict is only meaningful once the latency counter expires
  assign w_eval_done  = (r_state == ST_EVAL) && (r_dec_cnt == '0);
  assign w_hit        = (Result == RES_HIT);
  assign w_last_try   = (tries_left <= 3'd1);
  assign w_last_round = (round_idx == C_LAST_ROUND);

  // State register
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and state-derived outputs
  always_comb begin
    w_next      = r_state;
    guess_ready = 1'b0;
    dec_reset   = 1'b0;
    round_done  = 1'b0;
    round_win   = 1'b0;
    match_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        dec_reset = 1'b1;
        if (start) w_next = ST_LOAD;
      end
      ST_LOAD: begin
        dec_reset = 1'b1;
        w_next    = ST_WAIT_GUESS;
      end
      ST_WAIT_GUESS: begin
        guess_ready = 1'b1;
        if (guess_valid) w_next = ST_EVAL;
      end
      ST_EVAL: begin
        // A no-verdict code is handled exactly like a miss
        if (w_eval_done) begin
          if (w_hit || w_last_try) w_next = ST_RESULT;
          else                     w_next = ST_WAIT_GUESS;
        end
      end
      ST_RESULT: begin
        round_done = 1'b1;
        round_win  = r_won;
        w_next     = w_last_round ? ST_DONE : ST_LOAD;
      end
      ST_DONE: begin
        match_done = 1'b1;
        if (start) w_next = ST_LOAD;
      end
      default: begin
        dec_reset = 1'b1;
        w_next    = ST_IDLE;
      end
    endcase
  end

  // Round datapath: secret/guess latches, latency counter, tries, score, index
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      Correct_guess <= 2'b00;
      In_wr         <= 2'b00;
      tries_left    <= C_MAX_TRIES;
      score         <= 4'd0;
      round_idx     <= 4'd0;
      r_dec_cnt     <= '0;
      r_won         <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            score     <= 4'd0;
            round_idx <= 4'd0;
          end
        end
        ST_LOAD: begin
          Correct_guess <= secret_in;
          tries_left    <= C_MAX_TRIES;
          r_won         <= 1'b0;
        end
        ST_WAIT_GUESS: begin
          if (guess_valid) begin
            In_wr     <= guess;
            r_dec_cnt <= C_DEC_LOAD;
          end
        end
        ST_EVAL: begin
          // Score and tries settle before RESULT so they are valid at the pulse
          if (r_dec_cnt != '0) begin
            r_dec_cnt <= r_dec_cnt - C_CNT_W'(1);
          end else if (w_hit) begin
            r_won <= 1'b1;
            score <= sat_inc(score);
          end else begin
            r_won <= 1'b0;
            if (tries_left != 3'd0) tries_left <= tries_left - 3'd1;
          end
        end
        ST_RESULT: begin
          if (!w_last_round) round_idx <= round_idx + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
